// File: rtl/display_scanner.sv
// Time-multiplexed scan driver for a bank of active-low 7-segment digits.
// Double-buffered BCD data, per-slot dead time, invalid-code and leading-zero blanking.
module display_scanner #(
    parameter int DIGITS       = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic                  load,
    input  logic                  lz_suppress,
    output logic [3:0]            binary_code,
    output logic                  enable,
    output logic [DIGITS-1:0]     digit_select,
    output logic                  frame_done,
    output logic                  load_pending
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(SLOT_CYCLES);

    localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PRE   = CW'(SLOT_CYCLES - 2);
    localparam logic [CW-1:0] CNT_ENTER = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t              state;
    logic [4*DIGITS-1:0] holding;
    logic [4*DIGITS-1:0] shadow;
    logic                pending;
    logic [IW-1:0]       idx;
    logic [CW-1:0]       cnt;
    logic                slot_end;
    logic                boundary;

    assign slot_end     = (cnt == CNT_LAST);
    assign boundary     = slot_end && (idx == IDX_LAST);
    assign load_pending = pending;

    // A digit is dark if its code is not BCD, or if it is a suppressed leading zero.
    function automatic logic visible(input logic [4*DIGITS-1:0] data,
                                     input logic [IW-1:0]       k,
                                     input logic                lz);
        logic [3:0] code;
        logic       upper_zero;
        code       = data[4*k +: 4];
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(k) && data[4*i +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        return (code <= 4'd9) && !(lz && (k != '0) && upper_zero);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= BLANK;
            holding      <= '0;
            shadow       <= '0;
            pending      <= 1'b0;
            idx          <= '0;
            cnt          <= '0;
            binary_code  <= 4'd0;
            enable       <= 1'b0;
            digit_select <= '1;
            frame_done   <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end

            if (slot_end) begin
                state <= BLANK;
            end else if (cnt == CNT_ENTER) begin
                state <= SHOW;
            end

            // Shadow only moves on the frame boundary; a load landing exactly there bypasses holding.
            if (load) begin
                holding <= digits_in;
            end
            if (boundary) begin
                if (load) begin
                    shadow <= digits_in;
                end else if (pending) begin
                    shadow <= holding;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            // Outputs follow the state one cycle later; frame_done is anticipated to land on the boundary cycle.
            binary_code  <= shadow[4*idx +: 4];
            enable       <= (state == SHOW) && visible(shadow, idx, lz_suppress);
            digit_select <= (state == SHOW) ? ~(DIGITS'(1) << idx) : '1;
            frame_done   <= (idx == IDX_LAST) && (cnt == CNT_PRE);
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2 (32-cycle frame).
module tb_display_scanner;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic        load = 1'b0;
    logic        lz_suppress = 1'b0;
    logic [3:0]  binary_code;
    logic        enable;
    logic [3:0]  digit_select;
    logic        frame_done;
    logic        load_pending;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    display_scanner #(
        .DIGITS(4),
        .SLOT_CYCLES(8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .digits_in(digits_in),
        .load(load),
        .lz_suppress(lz_suppress),
        .binary_code(binary_code),
        .enable(enable),
        .digit_select(digit_select),
        .frame_done(frame_done),
        .load_pending(load_pending)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges since reset release; samples are taken 1 time unit after an edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int m);
        while (cyc < m) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (digit_select !== 4'hF) begin failures++; $display("FAIL reset_sel got=%b want=1111", digit_select); end
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL reset_en got=%b want=0", enable); end
        checks++; if (binary_code !== 4'h0) begin failures++; $display("FAIL reset_code got=%h want=0", binary_code); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b want=0", frame_done); end
        checks++; if (load_pending !== 1'b0) begin failures++; $display("FAIL reset_lp got=%b want=0", load_pending); end
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_load_basic();
        logic [15:0] data;
        logic [3:0]  exp_sel;
        logic [3:0]  exp_code;
        int          low [2];
        int          s;
        int          c;
        data = 16'h1234;
        low[0] = 0;
        low[1] = 0;
        digits_in = data;
        load = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (load_pending !== 1'b1) begin failures++; $display("FAIL load_pending_rise got=%b want=1", load_pending); end
        wait_to(32);
        checks++; if (load_pending !== 1'b0) begin failures++; $display("FAIL load_pending_clear got=%b want=0", load_pending); end
        for (int m = 33; m <= 48; m++) begin
            wait_to(m);
            s = ((m - 1) / 8) % 4;
            c = (m - 1) % 8;
            exp_sel  = (c >= 2) ? ~(4'b0001 << s) : 4'hF;
            exp_code = data[4*s +: 4];
            if (c >= 2) low[s]++;
            checks++; if (digit_select !== exp_sel) begin failures++; $display("FAIL basic_sel m=%0d got=%b want=%b", m, digit_select, exp_sel); end
            checks++; if (binary_code !== exp_code) begin failures++; $display("FAIL basic_code m=%0d got=%h want=%h", m, binary_code, exp_code); end
            checks++; if (enable !== (c >= 2)) begin failures++; $display("FAIL basic_en m=%0d got=%b want=%b", m, enable, (c >= 2)); end
        end
        checks++; if (low[0] != 6) begin failures++; $display("FAIL slot0_low_cycles got=%0d want=6", low[0]); end
        checks++; if (low[1] != 6) begin failures++; $display("FAIL slot1_low_cycles got=%0d want=6", low[1]); end
    endtask

    task automatic test_lz_suppress();
        logic [3:0] exp_sel;
        logic [3:0] lz_en;
        logic [3:0] lz_code [4];
        lz_en = 4'b0011;
        lz_code[0] = 4'h0; lz_code[1] = 4'h7; lz_code[2] = 4'h0; lz_code[3] = 4'h0;
        lz_suppress = 1'b1;
        wait_to(50);
        digits_in = 16'h0070;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int s = 0; s < 4; s++) begin
            wait_to(64 + 8*s + 5);
            exp_sel = ~(4'b0001 << s);
            checks++; if (digit_select !== exp_sel) begin failures++; $display("FAIL lz_sel s=%0d got=%b want=%b", s, digit_select, exp_sel); end
            checks++; if (enable !== lz_en[s]) begin failures++; $display("FAIL lz_en s=%0d got=%b want=%b", s, enable, lz_en[s]); end
            checks++; if (binary_code !== lz_code[s]) begin failures++; $display("FAIL lz_code s=%0d got=%h want=%h", s, binary_code, lz_code[s]); end
        end
        lz_suppress = 1'b0;
        for (int s = 0; s < 4; s++) begin
            wait_to(96 + 8*s + 5);
            checks++; if (enable !== 1'b1) begin failures++; $display("FAIL nolz_en s=%0d got=%b want=1", s, enable); end
            checks++; if (binary_code !== lz_code[s]) begin failures++; $display("FAIL nolz_code s=%0d got=%h want=%h", s, binary_code, lz_code[s]); end
        end
    endtask

    task automatic test_invalid_code();
        logic [3:0] exp_sel;
        logic [3:0] inv_en;
        logic [3:0] inv_code [4];
        inv_en = 4'b0101;
        inv_code[0] = 4'h9; inv_code[1] = 4'hF; inv_code[2] = 4'h5; inv_code[3] = 4'hA;
        wait_to(126);
        digits_in = 16'hA5F9;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int s = 0; s < 4; s++) begin
            wait_to(128 + 8*s + 5);
            exp_sel = ~(4'b0001 << s);
            checks++; if (digit_select !== exp_sel) begin failures++; $display("FAIL inv_sel s=%0d got=%b want=%b", s, digit_select, exp_sel); end
            checks++; if (enable !== inv_en[s]) begin failures++; $display("FAIL inv_en s=%0d got=%b want=%b", s, enable, inv_en[s]); end
            checks++; if (binary_code !== inv_code[s]) begin failures++; $display("FAIL inv_code s=%0d got=%h want=%h", s, binary_code, inv_code[s]); end
        end
    endtask

    task automatic test_back_to_back();
        int seen_one;
        int c;
        seen_one = 0;
        wait_to(160);
        for (int m = 161; m <= 256; m++) begin
            wait_to(m);
            c = (m - 1) % 8;
            if (binary_code === 4'h1) seen_one++;
            if (m >= 193 && m <= 224 && c >= 2) begin
                checks++; if (binary_code !== 4'h2 || enable !== 1'b1) begin failures++; $display("FAIL b2b_last_wins m=%0d got=%h/%b want=2/1", m, binary_code, enable); end
            end
            if (m >= 225 && c >= 2) begin
                checks++; if (binary_code !== 4'h3 || enable !== 1'b1) begin failures++; $display("FAIL boundary_load m=%0d got=%h/%b want=3/1", m, binary_code, enable); end
            end
            if (m == 166) begin
                checks++; if (load_pending !== 1'b1) begin failures++; $display("FAIL b2b_pending got=%b want=1", load_pending); end
            end
            if (m == 224 || m == 225) begin
                checks++; if (load_pending !== 1'b0) begin failures++; $display("FAIL boundary_pending m=%0d got=%b want=0", m, load_pending); end
            end
            load = 1'b0;
            if (m == 165) begin digits_in = 16'h1111; load = 1'b1; end
            if (m == 170) begin digits_in = 16'h2222; load = 1'b1; end
            if (m == 223) begin digits_in = 16'h3333; load = 1'b1; end
        end
        load = 1'b0;
        checks++; if (seen_one != 0) begin failures++; $display("FAIL overwritten_code_seen got=%0d want=0", seen_one); end
    endtask

    task automatic test_free_run();
        int pulses;
        int last;
        int multi;
        pulses = 0;
        last = 0;
        multi = 0;
        for (int m = 257; m <= 352; m++) begin
            wait_to(m);
            if ($countones(~digit_select) > 1) multi++;
            if (frame_done === 1'b1) begin
                pulses++;
                checks++; if ((m % 32) != 31) begin failures++; $display("FAIL fd_phase m=%0d got=%0d want=31", m, m % 32); end
                if (last != 0) begin
                    checks++; if (m - last != 32) begin failures++; $display("FAIL fd_period got=%0d want=32", m - last); end
                end
                last = m;
            end
        end
        checks++; if (pulses != 3) begin failures++; $display("FAIL fd_count got=%0d want=3", pulses); end
        checks++; if (multi != 0) begin failures++; $display("FAIL multi_select got=%0d want=0", multi); end
    endtask

    task automatic test_reset_mid_show();
        logic [3:0] exp_sel;
        wait_to(355);
        digits_in = 16'h5555;
        load = 1'b1;
        tick();
        load = 1'b0;
        wait_to(357);
        checks++; if (load_pending !== 1'b1) begin failures++; $display("FAIL pre_reset_pending got=%b want=1", load_pending); end
        checks++; if (digit_select !== 4'b1110) begin failures++; $display("FAIL pre_reset_sel got=%b want=1110", digit_select); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (digit_select !== 4'hF) begin failures++; $display("FAIL async_sel got=%b want=1111", digit_select); end
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL async_en got=%b want=0", enable); end
        checks++; if (binary_code !== 4'h0) begin failures++; $display("FAIL async_code got=%h want=0", binary_code); end
        checks++; if (load_pending !== 1'b0) begin failures++; $display("FAIL async_lp got=%b want=0", load_pending); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        for (int s = 0; s < 4; s++) begin
            wait_to(8*s + 5);
            exp_sel = ~(4'b0001 << s);
            checks++; if (digit_select !== exp_sel) begin failures++; $display("FAIL post_sel s=%0d got=%b want=%b", s, digit_select, exp_sel); end
            checks++; if (binary_code !== 4'h0 || enable !== 1'b1) begin failures++; $display("FAIL post_zero s=%0d got=%h/%b want=0/1", s, binary_code, enable); end
        end
        wait_to(37);
        checks++; if (binary_code !== 4'h0 || load_pending !== 1'b0) begin failures++; $display("FAIL discarded_load got=%h/%b want=0/0", binary_code, load_pending); end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_lz_suppress();
        test_invalid_code();
        test_back_to_back();
        test_free_run();
        test_reset_mid_show();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
